// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch port.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam int MAX_ADDR_W = 64;

  // Flags a byte address that is not word aligned or points past the last word.
  function automatic logic addr_err(input logic [MAX_ADDR_W-1:0] addr,
                                    input int addr_w,
                                    input int idx_w);
    logic err;
    err = (addr[1:0] != 2'b00);
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if ((i >= idx_w + 2) && (i < addr_w) && addr[i]) err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response handshake between a fetch unit (master) and the memory (slave).
interface imem_fetch_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W word storage: synchronous write, enabled synchronous read (read-before-write).
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are loaded by software, so neither the array nor the read latch is reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Writable instruction memory behind a fixed-latency valid/ready fetch handshake.
// IDLE accepts a request, WAIT covers the extra latency, RESP holds the word until taken.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_fetch_port_if.slave         bus,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic                     busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  req_idx;
  logic              req_err;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  assign req_idx = bus.req_addr[2 +: IDX_W];
  assign req_err = addr_err(MAX_ADDR_W'(bus.req_addr), ADDR_W, IDX_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          idx_d  = req_idx;
          err_d  = req_err;
          rd_idx = req_idx;
          if (LATENCY == 1) begin
            state_d = RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // The array read latch is only loaded on RESP entry, so the word stays put under backpressure.
  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) && err_q;
  assign bus.rsp_data  = (state_q != RESP) ? '0 : (err_q ? NOP_WORD : rd_word);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: three builds (L=2/1024, L=1/16, L=4/64 with non-zero NOP).
module tb_imem_fetch_port;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int A_DEPTH = 1024;
  localparam int A_LAT   = 2;
  localparam int B_DEPTH = 16;
  localparam int B_LAT   = 1;
  localparam int C_DEPTH = 64;
  localparam int C_LAT   = 4;
  localparam logic [DW-1:0] C_NOP = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic          a_we, b_we, c_we;
  logic [9:0]    a_paddr;
  logic [3:0]    b_paddr;
  logic [5:0]    c_paddr;
  logic [DW-1:0] a_pdata, b_pdata, c_pdata;
  logic          busy_a, busy_b, busy_c;

  imem_fetch_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  imem_fetch_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
  imem_fetch_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus_c ();

  imem_fetch_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(A_DEPTH), .LATENCY(A_LAT), .NOP_WORD(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .prog_we(a_we), .prog_addr(a_paddr),
    .prog_data(a_pdata), .busy(busy_a));
  imem_fetch_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(B_DEPTH), .LATENCY(B_LAT), .NOP_WORD(32'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .prog_we(b_we), .prog_addr(b_paddr),
    .prog_data(b_pdata), .busy(busy_b));
  imem_fetch_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(C_DEPTH), .LATENCY(C_LAT), .NOP_WORD(C_NOP)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .prog_we(c_we), .prog_addr(c_paddr),
    .prog_data(c_pdata), .busy(busy_c));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_a(input logic [9:0] i, input logic [DW-1:0] d);
    a_we = 1'b1; a_paddr = i; a_pdata = d;
    step();
    a_we = 1'b0;
  endtask

  task automatic prog_b(input logic [3:0] i, input logic [DW-1:0] d);
    b_we = 1'b1; b_paddr = i; b_pdata = d;
    step();
    b_we = 1'b0;
  endtask

  task automatic prog_c(input logic [5:0] i, input logic [DW-1:0] d);
    c_we = 1'b1; c_paddr = i; c_pdata = d;
    step();
    c_we = 1'b0;
  endtask

  // Issue one fetch from IDLE with rsp_ready high; report latency and the first response.
  task automatic fetch_a(input logic [AW-1:0] addr, output int lat, output logic [DW-1:0] d, output logic e);
    bus_a.rsp_ready = 1'b1; bus_a.req_addr = addr; bus_a.req_valid = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    lat = 1;
    while (bus_a.rsp_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    d = bus_a.rsp_data; e = bus_a.rsp_err;
    step();
  endtask

  task automatic fetch_b(input logic [AW-1:0] addr, output int lat, output logic [DW-1:0] d, output logic e);
    bus_b.rsp_ready = 1'b1; bus_b.req_addr = addr; bus_b.req_valid = 1'b1;
    step();
    bus_b.req_valid = 1'b0;
    lat = 1;
    while (bus_b.rsp_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    d = bus_b.rsp_data; e = bus_b.rsp_err;
    step();
  endtask

  task automatic test_reset();
    step(); step();
    n_cmp++; if ({bus_a.rsp_valid, bus_a.rsp_err, busy_a, bus_a.req_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL reset_ctrl_a: got %b want 0001", {bus_a.rsp_valid, bus_a.rsp_err, busy_a, bus_a.req_ready}); end
    n_cmp++; if (bus_a.rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_data_a: got %h want 0", bus_a.rsp_data); end
    n_cmp++; if ({bus_b.rsp_valid, bus_b.rsp_err, busy_b, bus_b.req_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL reset_ctrl_b: got %b want 0001", {bus_b.rsp_valid, bus_b.rsp_err, busy_b, bus_b.req_ready}); end
    n_cmp++; if (bus_b.rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_data_b: got %h want 0", bus_b.rsp_data); end
    n_cmp++; if ({bus_c.rsp_valid, bus_c.rsp_err, busy_c, bus_c.req_ready} !== 4'b0001) begin
      n_bad++; $display("FAIL reset_ctrl_c: got %b want 0001", {bus_c.rsp_valid, bus_c.rsp_err, busy_c, bus_c.req_ready}); end
    n_cmp++; if (bus_c.rsp_data !== 32'h0) begin n_bad++; $display("FAIL reset_data_c: got %h want 0", bus_c.rsp_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_fetch();
    prog_a(10'd1, 32'h8001_060A);
    n_cmp++; if (bus_a.req_ready !== 1'b1) begin n_bad++; $display("FAIL lf_ready_idle: got %b want 1", bus_a.req_ready); end
    bus_a.rsp_ready = 1'b1; bus_a.req_addr = 32'h4; bus_a.req_valid = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    n_cmp++; if ({bus_a.req_ready, busy_a, bus_a.rsp_valid} !== 3'b010) begin
      n_bad++; $display("FAIL lf_wait: rdy/busy/vld got %b want 010", {bus_a.req_ready, busy_a, bus_a.rsp_valid}); end
    step();
    n_cmp++; if ({bus_a.req_ready, busy_a, bus_a.rsp_valid} !== 3'b011) begin
      n_bad++; $display("FAIL lf_resp: rdy/busy/vld got %b want 011", {bus_a.req_ready, busy_a, bus_a.rsp_valid}); end
    n_cmp++; if (bus_a.rsp_data !== 32'h8001_060A || bus_a.rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL lf_data: got %h err %b want 8001060a err 0", bus_a.rsp_data, bus_a.rsp_err); end
    step();
    n_cmp++; if ({bus_a.req_ready, busy_a, bus_a.rsp_valid} !== 3'b100 || bus_a.rsp_data !== 32'h0) begin
      n_bad++; $display("FAIL lf_idle: flags %b data %h want 100 data 0", {bus_a.req_ready, busy_a, bus_a.rsp_valid}, bus_a.rsp_data); end
  endtask

  task automatic test_error_fetch();
    int lat; logic [DW-1:0] d; logic e;
    fetch_a(32'h6, lat, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL err_misaligned: got err %b data %h want 1 0", e, d); end
    fetch_a(32'h1000, lat, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL err_range: got err %b data %h want 1 0", e, d); end
    fetch_a(32'h8000_0004, lat, d, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_msb: got err %b want 1", e); end
    prog_a(10'd1023, 32'hC0FF_EE01);
    fetch_a(32'hFFC, lat, d, e);
    n_cmp++; if (e !== 1'b0 || d !== 32'hC0FF_EE01 || lat !== A_LAT) begin
      n_bad++; $display("FAIL err_last_word: got err %b data %h lat %0d want 0 c0ffee01 %0d", e, d, lat, A_LAT); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w; int lat; int saw;
    w = $urandom;
    prog_a(10'd5, w);
    bus_a.rsp_ready = 1'b0; bus_a.req_addr = 32'h14; bus_a.req_valid = 1'b1;
    step();
    bus_a.req_addr = 32'h18;
    lat = 1;
    while (bus_a.rsp_valid !== 1'b1 && lat < 10) begin step(); lat++; end
    n_cmp++; if (lat !== A_LAT) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", lat, A_LAT); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== w || bus_a.rsp_err !== 1'b0 || bus_a.req_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold: vld %b data %h err %b rdy %b want 1 %h 0 0",
                          bus_a.rsp_valid, bus_a.rsp_data, bus_a.rsp_err, bus_a.req_ready, w); end
    end
    bus_a.rsp_ready = 1'b1; bus_a.req_valid = 1'b0;
    step();
    n_cmp++; if ({bus_a.rsp_valid, busy_a, bus_a.req_ready} !== 3'b001 || bus_a.rsp_data !== 32'h0) begin
      n_bad++; $display("FAIL bp_release: vld/busy/rdy %b data %h want 001 0", {bus_a.rsp_valid, busy_a, bus_a.req_ready}, bus_a.rsp_data); end
    saw = 0;
    for (int k = 0; k < 4; k++) begin step(); if (bus_a.rsp_valid === 1'b1) saw++; end
    n_cmp++; if (saw !== 0) begin n_bad++; $display("FAIL bp_ignored_req: got %0d responses want 0", saw); end
  endtask

  task automatic test_collision();
    int lat; logic [DW-1:0] d; logic e;
    prog_a(10'd3, 32'h1111_1111);
    bus_a.rsp_ready = 1'b1; bus_a.req_addr = 32'hC; bus_a.req_valid = 1'b1;
    a_we = 1'b1; a_paddr = 10'd3; a_pdata = 32'hDEAD_BEEF;
    step();
    bus_a.req_valid = 1'b0; a_we = 1'b0;
    step();
    n_cmp++; if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL col_early_write: vld %b data %h want 1 deadbeef", bus_a.rsp_valid, bus_a.rsp_data); end
    step();
    prog_a(10'd3, 32'h2222_2222);
    bus_a.req_addr = 32'hC; bus_a.req_valid = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    a_we = 1'b1; a_paddr = 10'd3; a_pdata = 32'hDEAD_BEEF;
    step();
    a_we = 1'b0;
    n_cmp++; if (bus_a.rsp_valid !== 1'b1 || bus_a.rsp_data !== 32'h2222_2222) begin
      n_bad++; $display("FAIL col_entry_write: vld %b data %h want 1 22222222", bus_a.rsp_valid, bus_a.rsp_data); end
    step();
    fetch_a(32'hC, lat, d, e);
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL col_after: got %h want deadbeef", d); end
    prog_c(6'd7, 32'h0A0A_0A0A);
    bus_c.rsp_ready = 1'b1; bus_c.req_addr = 32'h1C; bus_c.req_valid = 1'b1;
    step();
    bus_c.req_valid = 1'b0;
    c_we = 1'b1; c_paddr = 6'd7; c_pdata = 32'h0B0B_0B0B;
    step();
    c_we = 1'b0;
    step(); step();
    n_cmp++; if (bus_c.rsp_valid !== 1'b1 || bus_c.rsp_data !== 32'h0B0B_0B0B) begin
      n_bad++; $display("FAIL col_wait_write: vld %b data %h want 1 0b0b0b0b", bus_c.rsp_valid, bus_c.rsp_data); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat; int saw; logic [DW-1:0] d; logic e;
    bus_a.rsp_ready = 1'b1; bus_a.req_addr = 32'h4; bus_a.req_valid = 1'b1;
    step();
    bus_a.req_valid = 1'b0;
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL rm_inflight: busy %b want 1", busy_a); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus_a.rsp_valid, bus_a.rsp_err, busy_a, bus_a.req_ready} !== 4'b0001 || bus_a.rsp_data !== 32'h0) begin
      n_bad++; $display("FAIL rm_async: flags %b data %h want 0001 0",
                        {bus_a.rsp_valid, bus_a.rsp_err, busy_a, bus_a.req_ready}, bus_a.rsp_data); end
    step();
    rst_n = 1'b1;
    saw = 0;
    for (int k = 0; k < 5; k++) begin step(); if (bus_a.rsp_valid === 1'b1) saw++; end
    n_cmp++; if (saw !== 0) begin n_bad++; $display("FAIL rm_no_rsp: got %0d responses want 0", saw); end
    fetch_a(32'h4, lat, d, e);
    n_cmp++; if (d !== 32'h8001_060A || e !== 1'b0 || lat !== A_LAT) begin
      n_bad++; $display("FAIL rm_refetch: data %h err %b lat %0d want 8001060a 0 %0d", d, e, lat, A_LAT); end
  endtask

  task automatic test_lat1();
    int lat; logic [DW-1:0] d; logic e;
    prog_b(4'd15, 32'h5A5A_0F0F);
    fetch_b(32'h3C, lat, d, e);
    n_cmp++; if (lat !== B_LAT || e !== 1'b0 || d !== 32'h5A5A_0F0F) begin
      n_bad++; $display("FAIL l1_last: lat %0d err %b data %h want %0d 0 5a5a0f0f", lat, e, d, B_LAT); end
    fetch_b(32'h40, lat, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL l1_range: err %b data %h want 1 0", e, d); end
    prog_b(4'd2, 32'h0000_1234);
    bus_b.rsp_ready = 1'b1; bus_b.req_addr = 32'h8; bus_b.req_valid = 1'b1;
    b_we = 1'b1; b_paddr = 4'd2; b_pdata = 32'h0000_5678;
    step();
    bus_b.req_valid = 1'b0; b_we = 1'b0;
    n_cmp++; if (bus_b.rsp_valid !== 1'b1 || bus_b.rsp_data !== 32'h0000_1234) begin
      n_bad++; $display("FAIL l1_rbw: vld %b data %h want 1 00001234", bus_b.rsp_valid, bus_b.rsp_data); end
    step();
    fetch_b(32'h8, lat, d, e);
    n_cmp++; if (d !== 32'h0000_5678) begin n_bad++; $display("FAIL l1_after: got %h want 00005678", d); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    cnt = 0;
    bus_a.rsp_ready = 1'b1; bus_a.req_addr = 32'h4; bus_a.req_valid = 1'b1;
    for (int k = 0; k < 3 * (A_LAT + 1); k++) begin
      step();
      if (bus_a.rsp_valid === 1'b1) begin
        cnt++;
        n_cmp++; if (bus_a.rsp_data !== 32'h8001_060A) begin n_bad++; $display("FAIL b2b_data_a: got %h want 8001060a", bus_a.rsp_data); end
      end
    end
    bus_a.req_valid = 1'b0;
    n_cmp++; if (cnt !== 3) begin n_bad++; $display("FAIL b2b_rate_a: got %0d responses want 3", cnt); end
    cnt = 0;
    bus_b.rsp_ready = 1'b1; bus_b.req_addr = 32'h3C; bus_b.req_valid = 1'b1;
    for (int k = 0; k < 3 * (B_LAT + 1); k++) begin step(); if (bus_b.rsp_valid === 1'b1) cnt++; end
    bus_b.req_valid = 1'b0;
    n_cmp++; if (cnt !== 3) begin n_bad++; $display("FAIL b2b_rate_b: got %0d responses want 3", cnt); end
    step(); step();
  endtask

  // Reference: a word array updated on every program write; a fetch returns the word as it
  // stood just before its response edge, and errors follow plain address arithmetic.
  task automatic test_random();
    logic [DW-1:0] mdl [C_DEPTH];
    logic [DW-1:0] exp_d, want;
    logic          exp_e, rdy;
    logic [AW-1:0] addr;
    int            idx, hold;
    for (int i = 0; i < C_DEPTH; i++) begin
      mdl[i] = $urandom;
      prog_c(6'(i), mdl[i]);
    end
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        7:       addr = 32'($urandom_range(0, C_DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        8:       addr = ($urandom | 32'h100) & ~32'h3;
        9:       addr = 32'(C_DEPTH * 4);
        default: addr = 32'($urandom_range(0, C_DEPTH - 1)) * 4;
      endcase
      idx   = int'((addr / 4) % C_DEPTH);
      exp_e = (addr % 4 != 0) || (addr >= 32'(C_DEPTH * 4));
      n_cmp++; if (bus_c.req_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready: got %b want 1", bus_c.req_ready); end
      bus_c.req_addr = addr; bus_c.req_valid = 1'b1; bus_c.rsp_ready = 1'($urandom_range(0, 1));
      for (int k = 1; k <= C_LAT; k++) begin
        c_we    = 1'($urandom_range(0, 1));
        c_paddr = ($urandom_range(0, 1) == 1) ? 6'(idx) : 6'($urandom_range(0, C_DEPTH - 1));
        c_pdata = $urandom;
        if (k == C_LAT) exp_d = mdl[idx];
        step();
        if (c_we) mdl[c_paddr] = c_pdata;
        bus_c.req_valid = 1'($urandom_range(0, 1)); bus_c.req_addr = $urandom;
        if (k < C_LAT) begin
          n_cmp++; if ({bus_c.rsp_valid, busy_c, bus_c.req_ready} !== 3'b010) begin
            n_bad++; $display("FAIL rnd_wait: t %0d k %0d vld/busy/rdy %b want 010", t, k, {bus_c.rsp_valid, busy_c, bus_c.req_ready}); end
        end
      end
      c_we = 1'b0;
      want = exp_e ? C_NOP : exp_d;
      n_cmp++; if (bus_c.rsp_valid !== 1'b1 || bus_c.rsp_data !== want || bus_c.rsp_err !== exp_e) begin
        n_bad++; $display("FAIL rnd_resp: t %0d addr %h vld %b data %h err %b want 1 %h %b",
                          t, addr, bus_c.rsp_valid, bus_c.rsp_data, bus_c.rsp_err, want, exp_e); end
      hold = 0;
      do begin
        rdy = (hold >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        bus_c.rsp_ready = rdy;
        c_we = 1'($urandom_range(0, 1)); c_paddr = 6'(idx); c_pdata = $urandom;
        step();
        if (c_we) mdl[c_paddr] = c_pdata;
        c_we = 1'b0;
        hold++;
        n_cmp++;
        if (!rdy) begin
          if (bus_c.rsp_valid !== 1'b1 || bus_c.rsp_data !== want || bus_c.rsp_err !== exp_e) begin
            n_bad++; $display("FAIL rnd_hold: t %0d vld %b data %h err %b want 1 %h %b",
                              t, bus_c.rsp_valid, bus_c.rsp_data, bus_c.rsp_err, want, exp_e); end
        end else begin
          if ({bus_c.rsp_valid, bus_c.rsp_err, busy_c, bus_c.req_ready} !== 4'b0001 || bus_c.rsp_data !== 32'h0) begin
            n_bad++; $display("FAIL rnd_release: t %0d flags %b data %h want 0001 0",
                              t, {bus_c.rsp_valid, bus_c.rsp_err, busy_c, bus_c.req_ready}, bus_c.rsp_data); end
        end
      end while (!rdy);
      bus_c.req_valid = 1'b0;
    end
  endtask

  initial begin
    a_we = 1'b0; a_paddr = '0; a_pdata = '0;
    b_we = 1'b0; b_paddr = '0; b_pdata = '0;
    c_we = 1'b0; c_paddr = '0; c_pdata = '0;
    bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.rsp_ready = 1'b0;
    bus_c.req_valid = 1'b0; bus_c.req_addr = '0; bus_c.rsp_ready = 1'b0;
    test_reset();
    test_load_fetch();
    test_error_fetch();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_lat1();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised, writable instruction memory with a valid/ready fetch handshake.
- Supersedes the fixed 1024-word combinational instruction ROM in the multicycle MIPS datapath.
- The fetch unit issues byte addresses and receives the instruction word after a configurable number of wait cycles.
- A program-load port fills the array at run time, so no instruction words are hard-coded.
- Misaligned and out-of-range fetches are flagged and return the NOP encoding.

Parameters:
- DATA_W, 32: instruction word width.
- ADDR_W, 32: byte-address width of req_addr.
- DEPTH, 1024: number of words. Must be a power of two, 2 or more.
- LATENCY, 1: cycles from request accept to rsp_valid. Must be 1 or more.
- NOP_WORD, 0: word returned on an errored fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  byte address of the instruction.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  fetched instruction word.
- rsp_err  out  1  fetch was misaligned or out of range.
- prog_we  in  1  program-load write enable.
- prog_addr  in  $clog2(DEPTH)  word index to write.
- prog_data  in  DATA_W  word to write.
- busy  out  1  a fetch is in flight.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; any in-flight fetch is discarded and produces no response.
  - Output values during and after reset: rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, req_ready=1.
  - Storage contents are not reset and are unspecified at power-up; software loads them via the prog port.
- State machine, states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. When req_valid=1, the request is accepted at that edge. The block latches idx = req_addr[2 +: log2(DEPTH)] and err.
    - err = (req_addr[1:0] != 0) OR (req_addr[ADDR_W-1 : log2(DEPTH)+2] != 0).
    - If LATENCY==1, go to RESP; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. cnt decrements each cycle; at cnt==0, go to RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready=1; on that edge, go to IDLE.
- Timing:
  - rsp_valid rises exactly LATENCY edges after the accept edge.
  - req_ready is combinational from state only (state==IDLE), so there are no back-to-back accepts.
  - Maximum throughput is one fetch per LATENCY+1 cycles with rsp_ready held at 1.
- Data sampling:
  - rsp_data is registered and sampled from the array on the edge that enters RESP.
  - On an errored fetch, rsp_data=NOP_WORD and rsp_err=1.
  - rsp_data and rsp_err clear to 0 on the RESP-to-IDLE edge.
- busy = (state != IDLE).
- Program port:
  - A write happens on each edge where prog_we=1, in any state.
  - A write to idx on the same edge that enters RESP is not seen: read-before-write, old word returned.
  - A write on any earlier edge of the fetch is seen.
- No combinational path from rsp_ready or req_valid to any output other than through the state register.

Decomposition:
- Package imem_pkg:
  - State enum {IDLE, WAIT, RESP}.
  - Default NOP_WORD constant.
  - Helper function computing the error condition from address, DEPTH and ADDR_W.
- Sub-module imem_array:
  - DEPTH x DATA_W storage.
  - Synchronous write port.
  - Synchronous read with enable, read-before-write.
- imem_fetch_port holds the FSM, wait counter, error decode and response registers.

Test Plan:
1. Load and fetch (LATENCY=2): load word 1 = 0x8001060A via prog. Fetch 0x4 with rsp_ready=1 → rsp_valid exactly 2 edges after accept, rsp_data=0x8001060A, rsp_err=0, busy high for 2 cycles, req_ready=0 in between.
2. Error fetches: fetch 0x6 → rsp_err=1, rsp_data=0x00000000. Fetch 0x1000 with DEPTH=1024 → rsp_err=1.
3. Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, req_ready=0, a new req_valid is ignored. Release → one-cycle handshake, then back to IDLE.
4. Write collision: with a fetch of index 3 in flight, write 0xDEADBEEF to index 3 during WAIT → response is 0xDEADBEEF. Same write on the RESP-entry edge → old word returned.
5. Reset mid-operation: assert rst_n=0 in WAIT → outputs immediately at reset values, no response after release, next fetch works normally.
6. LATENCY=1, DEPTH=16 build: fetch 0x3C → valid next edge, rsp_err=0. Fetch 0x40 → rsp_err=1.
